// File: rtl/pong_pkg.sv
// Shared definitions for the pong referee: state encoding, winner codes and
// parameter defaults.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    localparam logic [1:0] DIR_RESET = 2'b01;

    localparam int unsigned WIN_SCORE_DEF    = 7;
    localparam int unsigned SERVE_FRAMES_DEF = 60;
    localparam int unsigned POINT_FRAMES_DEF = 90;

endpackage

// File: rtl/pong_referee_if.sv
// Referee bus: game-datapath events in, referee decisions and scores out.
// No handshake here: frame/miss_l/miss_r/serve are single-cycle strobes
// qualified only by the clock; start_n is a raw asynchronous level.
interface pong_referee_if;
    logic       frame;
    logic       miss_l;
    logic       miss_r;
    logic       start_n;
    logic       run;
    logic       serve;
    logic [1:0] serve_dir;
    logic [3:0] lf_score;
    logic [3:0] rt_score;
    logic [1:0] winner;
    logic [2:0] state;

    modport master (
        output frame, miss_l, miss_r, start_n,
        input  run, serve, serve_dir, lf_score, rt_score, winner, state
    );

    modport slave (
        input  frame, miss_l, miss_r, start_n,
        output run, serve, serve_dir, lf_score, rt_score, winner, state
    );
endinterface

// File: rtl/pong_referee_key_sync.sv
// Start button synchroniser and falling-edge detector producing a one-cycle
// press strobe.
module key_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic press_o
);
    logic [1:0] sync_q;
    logic       prev_q;
    logic [2:0] vld_q;

    // vld_q marks when prev_q holds a real post-reset sample, so a button held
    // down through reset never looks like a fresh press.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            vld_q  <= 3'b000;
        end else begin
            sync_q <= {sync_q[0], key_ni};
            prev_q <= sync_q[1];
            vld_q  <= {vld_q[1:0], 1'b1};
        end
    end

    assign press_o = vld_q[2] & prev_q & ~sync_q[1];
endmodule

// File: rtl/pong_referee.sv
// Pong match referee: serve/play/point/over sequencing, frame timer,
// score keeping and winner decision.
module pong_referee
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = WIN_SCORE_DEF,
    parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int unsigned POINT_FRAMES = POINT_FRAMES_DEF
) (
    input  logic           clock_i,
    input  logic           reset_n_i,
    pong_referee_if.slave  bus
);
    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] lf_q, lf_d;
    logic [3:0] rt_q, rt_d;
    logic [1:0] winner_q, winner_d;
    logic [1:0] dir_q, dir_d;
    logic       serve_q, serve_d;
    logic       press;

    key_sync u_key_sync (
        .clk_i   (clock_i),
        .rst_ni  (reset_n_i),
        .key_ni  (bus.start_n),
        .press_o (press)
    );

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            timer_q  <= 8'd0;
            lf_q     <= 4'd0;
            rt_q     <= 4'd0;
            winner_q <= WIN_NONE;
            dir_q    <= DIR_RESET;
            serve_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            lf_q     <= lf_d;
            rt_q     <= rt_d;
            winner_q <= winner_d;
            dir_q    <= dir_d;
            serve_q  <= serve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        lf_d     = lf_q;
        rt_d     = rt_q;
        winner_d = winner_q;
        dir_d    = dir_q;
        serve_d  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (press) begin
                    state_d  = ST_SERVE;
                    timer_d  = 8'(SERVE_FRAMES);
                    lf_d     = 4'd0;
                    rt_d     = 4'd0;
                    winner_d = WIN_NONE;
                    serve_d  = 1'b1;
                end
            end
            ST_SERVE, ST_POINT: begin
                if (bus.frame) begin
                    if (timer_q <= 8'd1) begin
                        if (state_q == ST_SERVE) begin
                            state_d = ST_PLAY;
                            timer_d = 8'd0;
                        end else begin
                            state_d = ST_SERVE;
                            timer_d = 8'(SERVE_FRAMES);
                            serve_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                // A coincident FRAME is deliberately not counted on a point edge.
                if (bus.miss_l && bus.miss_r) begin
                    state_d = ST_POINT;
                    timer_d = 8'(POINT_FRAMES);
                end else if (bus.miss_l) begin
                    rt_d  = rt_q + 4'd1;
                    dir_d = {~dir_q[1], 1'b0};
                    if (rt_d == 4'(WIN_SCORE)) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_RIGHT;
                    end else begin
                        state_d = ST_POINT;
                        timer_d = 8'(POINT_FRAMES);
                    end
                end else if (bus.miss_r) begin
                    lf_d  = lf_q + 4'd1;
                    dir_d = {~dir_q[1], 1'b1};
                    if (lf_d == 4'(WIN_SCORE)) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_LEFT;
                    end else begin
                        state_d = ST_POINT;
                        timer_d = 8'(POINT_FRAMES);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.run       = (state_q == ST_PLAY);
    assign bus.serve     = serve_q;
    assign bus.serve_dir = dir_q;
    assign bus.lf_score  = lf_q;
    assign bus.rt_score  = rt_q;
    assign bus.winner    = winner_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_pong_referee.sv
// Directed bench for pong_referee with WIN_SCORE=3, SERVE_FRAMES=2,
// POINT_FRAMES=2; expected values are hand-computed constants.
module tb_pong_referee;
    logic clock;
    logic reset_n;
    int   vectors;
    int   miscompares;

    pong_referee_if bus ();

    pong_referee #(
        .WIN_SCORE    (3),
        .SERVE_FRAMES (2),
        .POINT_FRAMES (2)
    ) dut (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input string field,
                       input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st,
                           input logic run, input logic srv,
                           input logic [1:0] dir, input logic [3:0] lf,
                           input logic [3:0] rt, input logic [1:0] win);
        chk(tag, "state",  8'(bus.state),     8'(st));
        chk(tag, "run",    8'(bus.run),       8'(run));
        chk(tag, "serve",  8'(bus.serve),     8'(srv));
        chk(tag, "dir",    8'(bus.serve_dir), 8'(dir));
        chk(tag, "lf",     8'(bus.lf_score),  8'(lf));
        chk(tag, "rt",     8'(bus.rt_score),  8'(rt));
        chk(tag, "winner", 8'(bus.winner),    8'(win));
    endtask

    task automatic pulse(input logic f, input logic ml, input logic mr);
        bus.frame  = f;
        bus.miss_l = ml;
        bus.miss_r = mr;
        tick();
        bus.frame  = 1'b0;
        bus.miss_l = 1'b0;
        bus.miss_r = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
            if (i < n - 1) tick();
        end
    endtask

    // Press lands on the third edge after START falls; hold low 5 cycles.
    task automatic press_start(input string tag);
        bus.start_n = 1'b0;
        repeat (3) tick();
        chk(tag, "state", 8'(bus.state), 8'd1);
        chk(tag, "serve", 8'(bus.serve), 8'd1);
        tick();
        chk(tag, "serve_end", 8'(bus.serve), 8'd0);
        tick();
        bus.start_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        bus.frame   = 1'b0;
        bus.miss_l  = 1'b0;
        bus.miss_r  = 1'b0;
        bus.start_n = 1'b1;
        repeat (3) tick();
        chk_all("reset", 3'd0, 1'b0, 1'b0, 2'b01, 4'd0, 4'd0, 2'b00);
        reset_n = 1'b1;
        repeat (4) tick();

        pulse(1'b1, 1'b0, 1'b1);
        tick();
        chk_all("idle_ignore", 3'd0, 1'b0, 1'b0, 2'b01, 4'd0, 4'd0, 2'b00);

        press_start("press1");
        chk_all("serve1", 3'd1, 1'b0, 1'b0, 2'b01, 4'd0, 4'd0, 2'b00);
        frames(1);
        chk_all("serve1_f1", 3'd1, 1'b0, 1'b0, 2'b01, 4'd0, 4'd0, 2'b00);
        tick();
        frames(1);
        chk_all("play1", 3'd2, 1'b1, 1'b0, 2'b01, 4'd0, 4'd0, 2'b00);

        pulse(1'b0, 1'b1, 1'b0);
        chk_all("miss_l", 3'd3, 1'b0, 1'b0, 2'b10, 4'd0, 4'd1, 2'b00);
        frames(2);
        chk_all("point_exit", 3'd1, 1'b0, 1'b1, 2'b10, 4'd0, 4'd1, 2'b00);
        tick();
        chk_all("serve2", 3'd1, 1'b0, 1'b0, 2'b10, 4'd0, 4'd1, 2'b00);
        frames(2);
        chk_all("play2", 3'd2, 1'b1, 1'b0, 2'b10, 4'd0, 4'd1, 2'b00);

        pulse(1'b1, 1'b0, 1'b1);
        chk_all("frame_miss_r", 3'd3, 1'b0, 1'b0, 2'b01, 4'd1, 4'd1, 2'b00);
        tick();
        frames(1);
        chk_all("point_t1", 3'd3, 1'b0, 1'b0, 2'b01, 4'd1, 4'd1, 2'b00);
        tick();
        frames(1);
        chk_all("point_t0", 3'd1, 1'b0, 1'b1, 2'b01, 4'd1, 4'd1, 2'b00);
        tick();
        frames(2);
        chk_all("play3", 3'd2, 1'b1, 1'b0, 2'b01, 4'd1, 4'd1, 2'b00);

        bus.start_n = 1'b0;
        repeat (6) tick();
        bus.start_n = 1'b1;
        repeat (3) tick();
        chk_all("play_press", 3'd2, 1'b1, 1'b0, 2'b01, 4'd1, 4'd1, 2'b00);

        pulse(1'b0, 1'b1, 1'b1);
        chk_all("void", 3'd3, 1'b0, 1'b0, 2'b01, 4'd1, 4'd1, 2'b00);
        tick();
        frames(4);
        chk_all("play4", 3'd2, 1'b1, 1'b0, 2'b01, 4'd1, 4'd1, 2'b00);

        pulse(1'b0, 1'b0, 1'b1);
        chk_all("lf2", 3'd3, 1'b0, 1'b0, 2'b11, 4'd2, 4'd1, 2'b00);
        tick();
        frames(4);
        chk_all("play5", 3'd2, 1'b1, 1'b0, 2'b11, 4'd2, 4'd1, 2'b00);
        pulse(1'b0, 1'b0, 1'b1);
        chk_all("over", 3'd4, 1'b0, 1'b0, 2'b01, 4'd3, 4'd1, 2'b01);

        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b1, 1'b1);
        tick();
        chk_all("over_hold", 3'd4, 1'b0, 1'b0, 2'b01, 4'd3, 4'd1, 2'b01);

        press_start("press_over");
        chk_all("rematch", 3'd1, 1'b0, 1'b0, 2'b01, 4'd0, 4'd0, 2'b00);
        frames(2);
        pulse(1'b0, 1'b0, 1'b1);
        chk_all("rm_lf1", 3'd3, 1'b0, 1'b0, 2'b11, 4'd1, 4'd0, 2'b00);
        tick();
        frames(4);
        pulse(1'b0, 1'b0, 1'b1);
        tick();
        frames(4);
        chk_all("rm_play", 3'd2, 1'b1, 1'b0, 2'b01, 4'd2, 4'd0, 2'b00);

        reset_n     = 1'b0;
        bus.start_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_all("mid_reset", 3'd0, 1'b0, 1'b0, 2'b01, 4'd0, 4'd0, 2'b00);
        repeat (8) tick();
        chk_all("held_start", 3'd0, 1'b0, 1'b0, 2'b01, 4'd0, 4'd0, 2'b00);
        bus.start_n = 1'b1;
        repeat (3) tick();
        press_start("press_after_reset");
        chk_all("serve_after_reset", 3'd1, 1'b0, 1'b0, 2'b01, 4'd0, 4'd0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pong_referee.md
PONG_REFEREE -- requirements
Module: pong_referee

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 7, meaning the score that ends a match (1..15).
REQ-002 The block SHALL have parameter SERVE_FRAMES, default 60, meaning the frame count the ball is held before play starts (1..255).
REQ-003 The block SHALL have parameter POINT_FRAMES, default 90, meaning the frame count of the pause after a point (1..255).
REQ-004 CLOCK  in  1  sole clock; reset is synchronous and active-low.
REQ-005 RESET_N  in  1  synchronous active-low reset.
REQ-006 FRAME  in  1  one-cycle pulse per video frame, at the last pixel of the frame.
REQ-007 MISS_L  in  1  one-cycle pulse: ball left the field at the left edge.
REQ-008 MISS_R  in  1  one-cycle pulse: ball left the field at the right edge.
REQ-009 START  in  1  raw push-button level, active-low, asynchronous to CLOCK.
REQ-010 RUN  out  1  ball-motion enable to the game datapath.
REQ-011 SERVE  out  1  one-cycle pulse: recentre the ball and load SERVE_DIR.
REQ-012 SERVE_DIR  out  2  {y_dir, x_dir}, 1 = increasing coordinate.
REQ-013 LF_SCORE, RT_SCORE  out  4 each  left and right player scores.
REQ-014 WINNER  out  2  00 none, 01 left, 10 right.
REQ-015 STATE  out  3  current FSM state, for debug and overlay.

Function
REQ-016 START SHALL pass a 2-flop synchroniser; a press is a 1-to-0 transition of the synchronised level, one-cycle internal pulse.
REQ-017 FSM states SHALL be IDLE, SERVE, PLAY, POINT, OVER; transitions are taken on the clock edge after the qualifying input cycle.
REQ-018 IDLE: RUN=0; press -> SERVE; scores cleared to 0 on that transition.
REQ-019 Entering SERVE SHALL load the frame timer with SERVE_FRAMES and assert SERVE for exactly the first cycle in SERVE.
REQ-020 SERVE/POINT: each FRAME pulse decrements the timer; a FRAME with timer==1 exits (SERVE -> PLAY, POINT -> SERVE). FRAME is ignored in every other state.
REQ-021 PLAY: RUN=1 (Moore, decoded from the state register); RUN=0 in all other states.
REQ-022 PLAY, MISS_L alone -> RT_SCORE+1; MISS_R alone -> LF_SCORE+1.
REQ-023 PLAY, MISS_L and MISS_R in the same cycle SHALL be a void point: no score change, go to POINT, SERVE_DIR unchanged.
REQ-024 After a scoring event, if the new score == WIN_SCORE go to OVER with WINNER set to the scorer; otherwise go to POINT with the timer loaded to POINT_FRAMES.
REQ-025 On a scored point, SERVE_DIR.x SHALL point toward the player who conceded (MISS_L -> x=0, MISS_R -> x=1), and SERVE_DIR.y SHALL toggle.
REQ-026 MISS_L/MISS_R outside PLAY SHALL be ignored.
REQ-027 START presses in SERVE, PLAY and POINT SHALL be ignored.
REQ-028 OVER: RUN=0, scores and WINNER held; press -> SERVE with scores=0 and WINNER=00 on the same edge.
REQ-029 Scores SHALL never exceed WIN_SCORE.
REQ-030 The timer SHALL be 8-bit unsigned and never underflow.

Reset
REQ-031 With RESET_N=0 at a CLOCK edge, reset SHALL apply the following values, regardless of state, including mid-PLAY or mid-timer: STATE=IDLE, RUN=0, SERVE=0, SERVE_DIR=2'b01, LF_SCORE=RT_SCORE=0, WINNER=00, timer=0, synchroniser flops=1.
REQ-032 The first press SHALL be detectable no earlier than 3 cycles after reset release.

Structure
REQ-033 Package pong_pkg SHALL hold the state encoding (IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4), WINNER codes and parameter defaults.
REQ-034 Sub-module key_sync SHALL contain the synchroniser and falling-edge detector; the FSM, timer and scores SHALL stay in pong_referee.
REQ-035 The implementation SHALL use no latches and no gated clocks.

Verification (WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=2)
REQ-036 Reset, then START low for 5 cycles -> SERVE pulse of 1 cycle, STATE=1, SERVE_DIR=01; after 2 FRAME pulses, STATE=2 and RUN=1.
REQ-037 In PLAY, MISS_L -> RT_SCORE=1, STATE=3, SERVE_DIR=10; after 2 FRAMEs -> SERVE pulse, then PLAY after 2 more.
REQ-038 MISS_R three times across points -> LF_SCORE=3, STATE=4, WINNER=01, RUN=0; further MISS/FRAME -> no change; press -> STATE=1, scores 0, WINNER=00.
REQ-039 MISS_L and MISS_R in the same cycle in PLAY -> scores unchanged, STATE=3, SERVE_DIR unchanged.
REQ-040 RESET_N low for 1 cycle mid-PLAY with LF_SCORE=2 -> all outputs at reset values next cycle; START held low during reset gives no press until it is released and pressed again.
REQ-041 FRAME coincident with MISS_R in PLAY -> point scored, timer loaded to 2 (FRAME not counted); START press during PLAY -> ignored.
